// File: rtl/eth_mac_tx_framer.sv
// rtl/eth_mac_tx_framer.sv - Ethernet MAC transmit framer (preamble, SFD, payload, pad, FCS, IFG)
//
// Purpose: turns a payload byte stream (destination MAC .. end of payload) into a
// GMII-style byte/nibble stream with preamble, SFD, optional zero pad, CRC-32 FCS
// and inter-frame gap.
// Optional feature macro: ETH_TX_PAD_EN (zero-pad short frames to 60 payload bytes).
//
// Ports:
//   clk_i, reset_n_i       transmit clock, synchronous active-low reset
//   speed_i[1:0]           2'b1x byte mode (1000), 2'b0x nibble mode (10/100)
//   tx_ce_i                slot enable; nothing advances while low
//   data_i, v_i, last_i    payload byte stream in
//   ready_o                payload byte consumed when v_i & ready_o
//   txd_o, tx_en_o, tx_er_o  registered transmit outputs
//   busy_o                 framer is not idle
module eth_mac_tx_framer #(
  parameter int MAX_FRAME_p = 1514,
  parameter int IFG_BYTES_p = 12
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [1:0] speed_i,
  input  logic       tx_ce_i,
  input  logic [7:0] data_i,
  input  logic       v_i,
  input  logic       last_i,
  output logic       ready_o,
  output logic [7:0] txd_o,
  output logic       tx_en_o,
  output logic       tx_er_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG, S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic        byte_mode_q;
  logic        phase_q;      // nibble phase: 0 = low nibble slot start, 1 = high nibble
  logic [10:0] byte_cnt_q;
  logic [10:0] cnt_inc;
  logic [31:0] crc_q;
  logic [31:0] fcs;
  logic [15:0] slot_cnt_q;
  logic [3:0]  hold_q;       // high nibble sent on the second nibble cycle
  logic [7:0]  txd_q;
  logic        tx_en_q;
  logic        tx_er_q;

  logic        tick;         // enabled cycle that starts a byte time
  logic        accept;
  logic        underrun;
  logic        oversize;
  logic        start;
  logic        active;
  logic        pad_tick;

  logic [7:0]  slot_byte;
  logic        slot_en;
  logic        slot_er;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign tick     = tx_ce_i & (byte_mode_q | ~phase_q);
  assign ready_o  = ((state_q == S_DATA) & tick) | (state_q == S_DRAIN);
  assign accept   = (state_q == S_DATA) & tick & v_i;
  assign underrun = (state_q == S_DATA) & tick & ~v_i;
  assign oversize = accept & (byte_cnt_q == 11'(MAX_FRAME_p));
  assign cnt_inc  = byte_cnt_q + 11'd1;
  assign start    = (state_d == S_PRE) & (state_q != S_PRE);
  assign active   = (state_q != S_IDLE) & (state_q != S_DRAIN);
  assign fcs      = ~crc_q;
  assign busy_o   = (state_q != S_IDLE);
  assign txd_o    = txd_q;
  assign tx_en_o  = tx_en_q;
  assign tx_er_o  = tx_er_q;

`ifdef ETH_TX_PAD_EN
  assign pad_tick = (state_q == S_PAD) & tick;
`else
  assign pad_tick = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; everything except DRAIN moves on byte-time boundaries
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (tick & v_i) state_d = S_PRE;
      S_PRE:  if (tick & (slot_cnt_q == 16'd6)) state_d = S_SFD;
      S_SFD:  if (tick) state_d = S_DATA;
      S_DATA: begin
        if (underrun) state_d = S_DRAIN;
        else if (oversize) state_d = last_i ? S_IFG : S_DRAIN;
        else if (accept & last_i) begin
`ifdef ETH_TX_PAD_EN
          state_d = (cnt_inc < 11'd60) ? S_PAD : S_FCS;
`else
          state_d = S_FCS;
`endif
        end
      end
`ifdef ETH_TX_PAD_EN
      S_PAD:  if (tick & (cnt_inc == 11'd60)) state_d = S_FCS;
`endif
      S_FCS:  if (tick & (slot_cnt_q == 16'd3)) state_d = S_IFG;
      // The last gap slot doubles as the start edge of a waiting frame, so
      // back-to-back frames see exactly IFG_BYTES_p idle byte times.
      S_IFG:  if (tick & (slot_cnt_q == 16'(IFG_BYTES_p - 1))) state_d = v_i ? S_PRE : S_IDLE;
      S_DRAIN: if (tx_ce_i & v_i & last_i) state_d = S_IFG;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: the byte and flags for the slot that starts on this tick
  always_comb begin
    slot_byte = 8'h00;
    slot_en   = 1'b0;
    slot_er   = 1'b0;
    case (state_q)
      S_PRE: begin slot_byte = 8'h55; slot_en = 1'b1; end
      S_SFD: begin slot_byte = 8'hD5; slot_en = 1'b1; end
      S_DATA: begin
        slot_en   = 1'b1;
        slot_er   = underrun | oversize;
        slot_byte = v_i ? data_i : 8'h00;
      end
`ifdef ETH_TX_PAD_EN
      S_PAD: slot_en = 1'b1;
`endif
      S_FCS: begin
        slot_en = 1'b1;
        case (slot_cnt_q[1:0])
          2'd0:    slot_byte = fcs[7:0];
          2'd1:    slot_byte = fcs[15:8];
          2'd2:    slot_byte = fcs[23:16];
          default: slot_byte = fcs[31:24];
        endcase
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      byte_mode_q <= 1'b0;
      phase_q     <= 1'b0;
      byte_cnt_q  <= 11'd0;
      crc_q       <= 32'hFFFF_FFFF;
      slot_cnt_q  <= 16'd0;
      hold_q      <= 4'h0;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
    end else begin
      if (tx_ce_i) phase_q <= phase_q ? 1'b0 : (active & ~byte_mode_q);
      if (start) byte_mode_q <= (speed_i == 2'b10) | (speed_i == 2'b11);

      if (state_d != state_q) slot_cnt_q <= 16'd0;
      else if (tick)          slot_cnt_q <= slot_cnt_q + 16'd1;

      if (start) begin
        byte_cnt_q <= 11'd0;
        crc_q      <= 32'hFFFF_FFFF;
      end else if (accept) begin
        byte_cnt_q <= cnt_inc;
        crc_q      <= crc_byte(crc_q, data_i);
      end else if (pad_tick) begin
        byte_cnt_q <= cnt_inc;
        crc_q      <= crc_byte(crc_q, 8'h00);
      end

      if (tx_ce_i) begin
        if (tick) begin
          txd_q   <= byte_mode_q ? slot_byte : {4'h0, slot_byte[3:0]};
          hold_q  <= slot_byte[7:4];
          tx_en_q <= slot_en;
          tx_er_q <= slot_er;
        end else begin
          txd_q <= {4'h0, hold_q};
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_mac_tx_framer.sv
// tb/tb_eth_mac_tx_framer.sv - self-checking bench for eth_mac_tx_framer
module tb_eth_mac_tx_framer;

  localparam int MAX_FRAME = 1514;
  localparam int IFG       = 12;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] d;
    logic       en;
    logic       er;
  } slot_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] speed;
  logic       tx_ce;
  logic [7:0] data;
  logic       v;
  logic       last;
  logic       ready;
  logic [7:0] txd;
  logic       tx_en;
  logic       tx_er;
  logic       busy;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    ce_div   = 1;
  logic  ce_seen  = 1'b0;
  slot_t mon_q[$];

  always #5 clk = ~clk;

  eth_mac_tx_framer #(.MAX_FRAME_p(MAX_FRAME), .IFG_BYTES_p(IFG)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .speed_i   (speed),
    .tx_ce_i   (tx_ce),
    .data_i    (data),
    .v_i       (v),
    .last_i    (last),
    .ready_o   (ready),
    .txd_o     (txd),
    .tx_en_o   (tx_en),
    .tx_er_o   (tx_er),
    .busy_o    (busy)
  );

  // Record one output slot per enabled edge
  always @(posedge clk) ce_seen <= tx_ce;
  always @(negedge clk) begin
    if (ce_seen) begin
      slot_t s;
      s.d  = txd;
      s.en = tx_en;
      s.er = tx_er;
      mon_q.push_back(s);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    tx_ce = ((cyc % ce_div) == 0);
  endtask

  // Reference: standard reflected CRC-32, bit at a time
  function automatic logic [31:0] crc32(input bq_t q);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        logic fb;
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  function automatic bq_t model_frame(input bq_t p);
    bq_t o;
    bq_t q;
    logic [31:0] c;
    q = p;
`ifdef ETH_TX_PAD_EN
    while (q.size() < 60) q.push_back(8'h00);
`endif
    for (int i = 0; i < 7; i++) o.push_back(8'h55);
    o.push_back(8'hD5);
    foreach (q[i]) o.push_back(q[i]);
    c = crc32(q);
    for (int k = 0; k < 4; k++) o.push_back(c[8*k +: 8]);
    return o;
  endfunction

  function automatic bq_t rand_payload(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom));
    return p;
  endfunction

  task automatic check_idle_outs(input string tag);
    check_eq({tag, "_txd"},   32'(txd),   32'h0);
    check_eq({tag, "_en"},    32'(tx_en), 32'h0);
    check_eq({tag, "_er"},    32'(tx_er), 32'h0);
    check_eq({tag, "_busy"},  32'(busy),  32'h0);
    check_eq({tag, "_ready"}, 32'(ready), 32'h0);
  endtask

  task automatic send_frame(input string tag, input bq_t p, input int under_at, input int rst_at);
    int idx = 0;
    int budget = 0;
    bit dropped = 0;
    bit hs;
    while (idx < p.size()) begin
      if (budget > 20000) begin
        check_eq({tag, "_send_timeout"}, 32'd1, 32'd0);
        break;
      end
      if (rst_at >= 0 && idx == rst_at) begin
        reset_n = 1'b0;
        v = 1'b0;
        last = 1'b0;
        step();
        check_idle_outs({tag, "_after_rst"});
        reset_n = 1'b1;
        return;
      end
      if (under_at >= 0 && idx == under_at && !dropped) begin
        v = 1'b0;
        last = 1'b0;
        dropped = 1;
      end else begin
        v = 1'b1;
        data = p[idx];
        last = (idx == p.size() - 1);
      end
      @(negedge clk);
      hs = v & ready & tx_ce;
      step();
      budget++;
      if (hs) idx++;
    end
  endtask

  // Idle the input and count the cycles until the framer is idle again
  task automatic finish_frame(input string tag, output int busy_cnt);
    int budget = 0;
    v = 1'b0;
    last = 1'b0;
    busy_cnt = 0;
    while (1) begin
      @(negedge clk);
      if (!busy) break;
      if (budget > 20000) begin
        check_eq({tag, "_idle_timeout"}, 32'd1, 32'd0);
        break;
      end
      busy_cnt++;
      budget++;
      step();
    end
    step();
  endtask

  // Compare the nth tx_en run in the recorded stream with an expected byte list
  task automatic check_run(input string tag, input int nth, input bq_t exp, input bit nib,
                           input int exp_er, output bq_t got, output int gap_after);
    int run = -1, start = -1, len = 0, gap = 0, mism = 0, ers = 0;
    bit seen_next = 0;
    logic last_er;
    got.delete();
    for (int i = 0; i < mon_q.size(); i++) begin
      if (mon_q[i].en && (i == 0 || !mon_q[i-1].en)) begin
        run++;
        if (run == nth + 1) seen_next = 1;
      end
      if (mon_q[i].en && run == nth) begin
        if (start < 0) start = i;
        len++;
      end
      if (!mon_q[i].en && run == nth && start >= 0) gap++;
    end
    gap_after = seen_next ? gap : -1;
    for (int j = 0; j < len; j++) begin
      slot_t s;
      int b;
      logic [7:0] e;
      s = mon_q[start + j];
      ers += int'(s.er);
      b = nib ? j / 2 : j;
      if (nib) e = (j % 2) ? {4'h0, exp[b][7:4]} : {4'h0, exp[b][3:0]};
      else     e = exp[b];
      if (b >= exp.size() || s.d !== e) mism++;
      if (!nib) got.push_back(s.d);
      else if (j % 2) got.push_back({s.d[3:0], mon_q[start + j - 1].d[3:0]});
    end
    last_er = (len > 0) ? mon_q[start + len - 1].er : 1'b0;
    check_eq({tag, "_len"},     32'(len),     32'(nib ? 2 * exp.size() : exp.size()));
    check_eq({tag, "_mism"},    32'(mism),    32'd0);
    check_eq({tag, "_er_cnt"},  32'(ers),     32'(exp_er));
    check_eq({tag, "_last_er"}, 32'(last_er), 32'(exp_er > 0));
  endtask

  initial begin
    bq_t p, p2, e, got;
    int  gap, bc;

    reset_n = 1'b0;
    v = 1'b0;
    last = 1'b0;
    data = 8'h00;
    speed = 2'b10;
    tx_ce = 1'b1;
    ce_div = 1;
    repeat (3) step();
    check_idle_outs("reset");
    reset_n = 1'b1;
    step();

    // Byte mode, incrementing 60-byte payload
    mon_q.delete();
    p.delete();
    for (int i = 0; i < 60; i++) p.push_back(8'(i));
    send_frame("inc60", p, -1, -1);
    finish_frame("inc60", bc);
    check_run("inc60", 0, model_frame(p), 0, 0, got, gap);

    // Short frame
    mon_q.delete();
`ifdef ETH_TX_PAD_EN
    p = rand_payload(10);
    send_frame("short", p, -1, -1);
    finish_frame("short", bc);
    check_run("short", 0, model_frame(p), 0, 0, got, gap);
    check_eq("short_slots", 32'(got.size()), 32'd72);
`else
    p.delete();
    for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
    send_frame("ascii9", p, -1, -1);
    finish_frame("ascii9", bc);
    check_run("ascii9", 0, model_frame(p), 0, 0, got, gap);
    check_eq("ascii9_fcs0", 32'(got[17]), 32'h26);
    check_eq("ascii9_fcs1", 32'(got[18]), 32'h39);
    check_eq("ascii9_fcs2", 32'(got[19]), 32'hF4);
    check_eq("ascii9_fcs3", 32'(got[20]), 32'hCB);
`endif

    // Nibble mode, enable every 5th cycle
    mon_q.delete();
    speed = 2'b01;
    ce_div = 5;
    p = rand_payload(60);
    send_frame("nib60", p, -1, -1);
    finish_frame("nib60", bc);
    check_run("nib60", 0, model_frame(p), 1, 0, got, gap);
    speed = 2'b10;
    ce_div = 1;

    // Underrun after 20 bytes
    mon_q.delete();
    p = rand_payload(40);
    send_frame("under", p, 20, -1);
    finish_frame("under", bc);
    check_eq("under_ifg_cycles", 32'(bc), 32'(IFG));
    e.delete();
    for (int i = 0; i < 7; i++) e.push_back(8'h55);
    e.push_back(8'hD5);
    for (int i = 0; i < 20; i++) e.push_back(p[i]);
    e.push_back(8'h00);
    check_run("under", 0, e, 0, 1, got, gap);
    check_eq("under_no_second_run", 32'(gap), 32'hFFFF_FFFF);

    // Back-to-back 64-byte frames
    mon_q.delete();
    p  = rand_payload(64);
    p2 = rand_payload(64);
    send_frame("b2b_a", p, -1, -1);
    send_frame("b2b_b", p2, -1, -1);
    finish_frame("b2b", bc);
    check_run("b2b_a", 0, model_frame(p), 0, 0, got, gap);
    check_eq("b2b_gap", 32'(gap), 32'(IFG));
    check_run("b2b_b", 1, model_frame(p2), 0, 0, got, gap);

    // Reset pulse during byte 30, then a clean frame
    p = rand_payload(50);
    send_frame("rst", p, -1, 30);
    step();
    mon_q.delete();
    p = rand_payload(60);
    send_frame("post_rst", p, -1, -1);
    finish_frame("post_rst", bc);
    check_run("post_rst", 0, model_frame(p), 0, 0, got, gap);

    // Largest legal frame, then one byte too many with last on it
    mon_q.delete();
    p = rand_payload(MAX_FRAME);
    send_frame("max", p, -1, -1);
    finish_frame("max", bc);
    check_run("max", 0, model_frame(p), 0, 0, got, gap);

    mon_q.delete();
    p = rand_payload(MAX_FRAME + 1);
    send_frame("over", p, -1, -1);
    finish_frame("over", bc);
    check_eq("over_ifg_cycles", 32'(bc), 32'(IFG));
    e.delete();
    for (int i = 0; i < 7; i++) e.push_back(8'h55);
    e.push_back(8'hD5);
    foreach (p[i]) e.push_back(p[i]);
    check_run("over", 0, e, 0, 1, got, gap);

    // Random frames, speeds and enable rates
    for (int r = 0; r < 4; r++) begin
      string tag;
      tag = $sformatf("rnd%0d", r);
      mon_q.delete();
      speed = 2'($urandom_range(0, 3));
      ce_div = $urandom_range(1, 3);
      p = rand_payload($urandom_range(1, 120));
      send_frame(tag, p, -1, -1);
      finish_frame(tag, bc);
      check_run(tag, 0, model_frame(p), speed < 2'b10, 0, got, gap);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_mac_tx_framer.md
# eth_mac_tx_framer

MAC-side Ethernet transmit framer for the ethernet controller. It accepts a frame's payload (destination MAC through end of payload) as a byte stream with valid/ready, then emits a complete GMII-style byte stream: preamble, SFD, payload, zero padding and FCS, followed by the inter-frame gap. It sits between the TX buffer and the RGMII DDR output stage, and produces what the PHY model's receive checker verifies. It supports 1000 Mb/s byte mode and 10/100 Mb/s nibble mode, paced by a clock enable.

## Interface
- MAX_FRAME_p, 1514: maximum payload bytes per frame (destination MAC through end of payload, FCS excluded).
- IFG_BYTES_p, 12: inter-frame gap, in byte times.
- clk_i  input  1  transmit clock.
- reset_n_i  input  1  reset; synchronous, active-low.
- speed_i  input  2  2'b10 selects 1000 Mb/s byte mode; 2'b00 or 2'b01 selects 10/100 nibble mode; 2'b11 is treated as byte mode.
- tx_ce_i  input  1  byte/nibble slot enable; all state advances only when this is 1.
- data_i  input  8  payload byte.
- v_i  input  1  data_i is valid.
- last_i  input  1  data_i is the final payload byte of the frame.
- ready_o  output  1  a payload byte is consumed this cycle when v_i & ready_o.
- txd_o  output  8  transmit data; in nibble mode only [3:0] is meaningful and [7:4] is 0.
- tx_en_o  output  1  transmit enable.
- tx_er_o  output  1  transmit error.
- busy_o  output  1  asserted whenever the state is not IDLE.

## Operation
- States and the slot count each occupies (one slot = one byte time):
  - IDLE.
  - PRE: 7 slots of 0x55.
  - SFD: 1 slot of 0xD5.
  - DATA.
  - PAD: bytes of 0x00.
  - FCS: 4 slots.
  - IFG: IFG_BYTES_p slots.
  - DRAIN.
- Frame start: in IDLE, tx_ce_i=1 and v_i=1 moves the state to PRE. No input byte is consumed on the start edge. speed_i is latched on this edge.
- DATA, byte consumption:
  - ready_o = (state==DATA) & tx_ce_i & (byte mode | nibble phase 0). ready_o is combinational.
  - Each accepted byte updates the CRC and increments an 11-bit byte counter.
- DATA, exit on last_i:
  - If the count is below 60, go to PAD.
  - Otherwise go to FCS.
- PAD: emit 0x00 until the byte count reaches 60, then go to FCS.
- CRC:
  - Reflected CRC-32, polynomial 0xEDB88320, initial value 0xFFFFFFFF.
  - Covers payload and pad bytes.
  - The final value is XORed with 0xFFFFFFFF.
  - FCS is sent least-significant byte first.
- Underrun: v_i=0 while ready_o would be 1.
  - That slot is sent with tx_er_o=1, tx_en_o=1 and txd_o=0x00.
  - The state goes to DRAIN.
- Oversize: a byte accepted with count == MAX_FRAME_p (that is, the (MAX_FRAME_p+1)th byte).
  - That slot is sent with tx_er_o=1.
  - If last_i is 0, go to DRAIN; otherwise go to IFG.
- DRAIN:
  - ready_o=1 and tx_en_o=0.
  - Input bytes are discarded until v_i & last_i, then the state goes to IFG.
- IFG:
  - tx_en_o=0.
  - v_i is ignored.
  - After the IFG, return to IDLE.
- Nibble mode: each byte takes 2 enabled cycles, low nibble first and high nibble second; tx_en_o is held for both cycles.
- tx_er_o is 0 in every slot except the underrun and oversize error slots.

## Timing
- Reset: state IDLE, txd_o=0, tx_en_o=0, tx_er_o=0, ready_o=0, busy_o=0, nibble phase 0, counters 0, CRC 0xFFFFFFFF.
- Reset asserted mid-frame takes effect on the next edge. Outputs are forced low, and the partial frame is simply truncated.
- txd_o, tx_en_o and tx_er_o are registered and update only on edges where tx_ce_i=1. When tx_ce_i=0, they hold their values.
- Byte mode:
  - The first 0x55 appears 1 enabled cycle after the start edge.
  - A byte accepted on enabled cycle t appears on txd_o at t+1.
- Back-to-back frames: tx_en_o is low for exactly IFG_BYTES_p byte times (twice that many enabled cycles in nibble mode).
- last_i together with v_i=0 is ignored.
- A speed_i change mid-frame has no effect until the next IDLE exit.

## Configuration
- ETH_TX_PAD_EN:
  - Defined: short frames are zero-padded to 60 payload bytes as above.
  - Undefined: the PAD state is removed, DATA goes directly to FCS, and frames shorter than 60 bytes are sent unpadded with the FCS computed over the payload only.

## Test plan
- Byte mode, 60 payload bytes 0x00..0x3B, tx_ce_i=1 -> 72 consecutive tx_en_o cycles: 7×0x55, 0xD5, the payload, then an FCS equal to the reference CRC-32; tx_er_o=0 throughout.
- Byte mode, 10-byte payload with ETH_TX_PAD_EN defined -> 50 bytes of 0x00 pad, 72 tx_en_o cycles, FCS computed over 60 bytes. Same stimulus without the macro, payload ASCII "123456789" (9 bytes) -> FCS bytes 0x26, 0x39, 0xF4, 0xCB; 21 tx_en_o cycles.
- Nibble mode (speed_i=2'b01), tx_ce_i=1 every 5th cycle, 60-byte frame -> txd_o[3:0] sequence 5,5,...(14 nibbles),5,D, then the payload low/high nibbles; 144 enabled tx_en_o slots.
- Underrun: v_i dropped for 1 cycle after byte 20 -> that slot has tx_er_o=1; then tx_en_o=0, remaining input drained through last_i, 12 idle byte times, back to IDLE.
- Two back-to-back 64-byte frames with v_i held high -> exactly 12 tx_en_o=0 cycles between them; both FCS values correct.
- Reset pulse (reset_n_i=0 for 1 cycle) during byte 30 of DATA -> all outputs 0 on the next cycle; a following frame is transmitted correctly.
